// File: rtl/tanh_pkg.sv
// rtl/tanh_pkg.sv - shared widths, fixed-point constants and loader state encoding
package tanh_pkg;
  localparam int N  = 32;
  localparam int Q  = 16;
  localparam int AW = 10;
  localparam int DW = 32;

  localparam logic [N-1:0] FX_ONE     = N'(1) << Q;
  localparam logic [N-1:0] FX_NEG_ONE = 32'hFFFF_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_e;
endpackage

// File: rtl/tanh_lut_loader_if.sv
// rtl/tanh_lut_loader_if.sv - sample stream, table write port and status of the tanh loader
interface tanh_lut_loader_if;
  import tanh_pkg::*;

  logic          start;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          busy;
  logic          table_valid;
  logic          err_mono;
  logic          err_range;
  logic [DW-1:0] checksum;

  modport master (
    output start, s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata, busy, table_valid,
           err_mono, err_range, checksum
  );

  modport slave (
    input  start, s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata, busy, table_valid,
           err_mono, err_range, checksum
  );
endinterface

// File: rtl/tanh_sample_check.sv
// rtl/tanh_sample_check.sv - combinational tanh-table invariant check for one sample
module tanh_sample_check
  import tanh_pkg::*;
(
  input  logic [N-1:0] i_sample,
  input  logic [N-1:0] i_prev,
  input  logic         i_first,
  output logic         o_mono_violation,
  output logic         o_range_violation
);

  assign o_mono_violation  = !i_first && ($signed(i_sample) < $signed(i_prev));
  assign o_range_violation = i_sample[N-1] || ($signed(i_sample) > $signed(FX_ONE));

endmodule

// File: rtl/tanh_lut_loader.sv
// rtl/tanh_lut_loader.sv - streams 2^AW tanh samples into the table RAM, checks them
// and raises table_valid only once every entry has been written
module tanh_lut_loader
  import tanh_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  tanh_lut_loader_if.slave bus
);

  ld_state_e     r_state;
  ld_state_e     w_next_state;
  logic [AW-1:0] r_cnt;
  logic [DW-1:0] r_prev;
  logic [DW-1:0] r_checksum;
  logic          r_err_mono;
  logic          r_err_range;
  logic          r_table_valid;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  logic w_xfer;
  logic w_last;
  logic w_clear;
  logic w_mono;
  logic w_range;

  assign w_xfer = (r_state == LOAD) && bus.s_valid;
  assign w_last = (r_cnt == {AW{1'b1}});

  tanh_sample_check u_check (
    .i_sample          (bus.s_data),
    .i_prev            (r_prev),
    .i_first           (r_cnt == '0),
    .o_mono_violation  (w_mono),
    .o_range_violation (w_range)
  );

  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    case (r_state)
      IDLE: if (bus.start) begin
        w_next_state = LOAD;
        w_clear      = 1'b1;
      end
      LOAD: if (w_xfer && w_last) w_next_state = DONE;
      DONE: if (bus.start) begin
        w_next_state = LOAD;
        w_clear      = 1'b1;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // table_valid rises the cycle after the final write so that write has landed in RAM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_prev        <= '0;
      r_checksum    <= '0;
      r_err_mono    <= 1'b0;
      r_err_range   <= 1'b0;
      r_table_valid <= 1'b0;
    end else if (w_clear) begin
      r_cnt         <= '0;
      r_prev        <= '0;
      r_checksum    <= '0;
      r_err_mono    <= 1'b0;
      r_err_range   <= 1'b0;
      r_table_valid <= 1'b0;
    end else if (w_xfer) begin
      r_cnt       <= w_last ? r_cnt : r_cnt + 1'b1;
      r_prev      <= bus.s_data;
      r_checksum  <= r_checksum + bus.s_data;
      r_err_mono  <= r_err_mono | w_mono;
      r_err_range <= r_err_range | w_range;
    end else if (r_state == DONE) begin
      r_table_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= w_xfer;
      if (w_xfer) begin
        r_mem_addr  <= r_cnt;
        r_mem_wdata <= bus.s_data;
      end
    end
  end

  assign bus.s_ready     = (r_state == LOAD);
  assign bus.busy        = (r_state == LOAD);
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.table_valid = r_table_valid;
  assign bus.err_mono    = r_err_mono;
  assign bus.err_range   = r_err_range;
  assign bus.checksum    = r_checksum;

endmodule

// File: tb/tb_tanh_lut_loader.sv
// tb/tb_tanh_lut_loader.sv - self-checking bench for tanh_lut_loader
module tb_tanh_lut_loader;
  import tanh_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tanh_lut_loader_if ifc();
  tanh_lut_loader dut (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  typedef struct {
    int          pat;
    bit          thr;
    int          start_at;
    bit          use_model;
    logic [31:0] cks;
    bit          mono;
    bit          rng;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] samp [1024];
  int          wr_idx = 0;
  int          wr_bad = 0;
  int          ready_bad = 0;
  bit          prev_xfer = 0;
  bit          tb_loading = 0;
  bit          mono_at [1024];
  bit          range_at [1024];
  bit          tv_pending = 0;
  logic        tv_at_last = 1'b0;
  logic        tv_after = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Write-port observer: every write must follow a transfer and carry the next sample in order
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_xfer = 0;
    end else begin
      if (tv_pending) begin
        tv_after   = ifc.table_valid;
        tv_pending = 0;
      end
      if (ifc.mem_we !== prev_xfer) wr_bad++;
      if (ifc.mem_we === 1'b1) begin
        if (wr_idx < 1024) begin
          if (ifc.mem_addr !== wr_idx[9:0] || ifc.mem_wdata !== samp[wr_idx]) wr_bad++;
          mono_at[wr_idx]  = ifc.err_mono;
          range_at[wr_idx] = ifc.err_range;
          if (wr_idx == 1023) begin
            tv_at_last = ifc.table_valid;
            tv_pending = 1;
          end
        end else begin
          wr_bad++;
        end
        wr_idx++;
      end
      if (ifc.s_ready !== tb_loading || ifc.busy !== tb_loading) ready_bad++;
      prev_xfer = ifc.s_valid && ifc.s_ready;
    end
  end

  task automatic fill(input int pat);
    logic [31:0] acc;
    acc = 0;
    for (int k = 0; k < 1024; k++) begin
      case (pat)
        4: begin
          acc = acc + $urandom_range(0, 63);
          samp[k] = acc;
        end
        5: samp[k] = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 32'h0001_0001);
        default: samp[k] = k * 64;
      endcase
    end
    if (pat == 2) begin
      samp[5] = 32'h0000_0100;
      samp[6] = 32'h0000_00FF;
    end
    if (pat == 3) begin
      samp[10] = 32'h0001_0001;
      samp[20] = 32'hFFFF_FFFF;
    end
  endtask

  task automatic model(output logic [31:0] cks, output bit mono, output bit rng);
    cks = 0; mono = 0; rng = 0;
    for (int k = 0; k < 1024; k++) begin
      cks = cks + samp[k];
      if (k > 0 && $signed(samp[k]) < $signed(samp[k-1])) mono = 1;
      if ($signed(samp[k]) < 0 || $signed(samp[k]) > 32'sh0001_0000) rng = 1;
    end
  endtask

  task automatic reset_monitor();
    wr_idx = 0; wr_bad = 0; ready_bad = 0;
    tv_pending = 0; tv_at_last = 1'b0; tv_after = 1'b0;
  endtask

  task automatic pulse_start();
    logic was_valid;
    was_valid = ifc.table_valid;
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    tb_loading = 1;
    if (was_valid === 1'b1) begin
      check("restart_tv_drop", ifc.table_valid, 0);
      check("restart_clear", {ifc.err_mono, ifc.err_range, ifc.checksum != 0}, 0);
    end
  endtask

  task automatic stream(input bit thr, input int start_at, input int reset_at, output bit aborted);
    int k;
    int cyc;
    bit rdy;
    k = 0; cyc = 0; aborted = 0;
    while (k < 1024 && cyc < 6000) begin
      ifc.s_valid = thr ? (cyc % 2 == 0) : 1'b1;
      ifc.s_data  = ifc.s_valid ? samp[k] : $urandom;
      ifc.start   = (k == start_at) && ifc.s_valid;
      rdy = ifc.s_ready;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      if (ifc.s_valid && rdy) k++;
      cyc++;
      if (k == reset_at) begin
        #2 rst_n = 1'b0;
        tb_loading = 0;
        #1;
        check("reset_async_outputs", |{ifc.mem_we, ifc.mem_addr, ifc.mem_wdata, ifc.busy, ifc.s_ready,
                                       ifc.table_valid, ifc.err_mono, ifc.err_range, ifc.checksum}, 0);
        ifc.s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        aborted = 1;
        break;
      end
    end
    ifc.s_valid = 1'b0;
    tb_loading = 0;
    check("xfer_budget", (k == 1024) || aborted, 1);
  endtask

  task automatic finish_checks(input string tag, input logic [31:0] cks, input bit mono, input bit rng);
    check({tag, "_checksum"}, ifc.checksum, cks);
    check({tag, "_err_mono"}, ifc.err_mono, mono);
    check({tag, "_err_range"}, ifc.err_range, rng);
    check({tag, "_write_count"}, wr_idx, 1024);
    check({tag, "_write_order"}, wr_bad, 0);
    check({tag, "_ready_phase"}, ready_bad, 0);
    check({tag, "_tv_at_last_write"}, tv_at_last, 0);
    check({tag, "_tv_after_last_write"}, tv_after, 1);
    check({tag, "_tv_hold"}, {ifc.table_valid, ifc.busy}, 2'b10);
  endtask

  vec_t vecs [6];

  initial begin
    logic [31:0] cks;
    bit mono, rng, ab;

    vecs[0] = '{pat: 0, thr: 0, start_at: -1,  use_model: 0, cks: 32'h01FF_8000, mono: 0, rng: 0};
    vecs[1] = '{pat: 0, thr: 1, start_at: -1,  use_model: 0, cks: 32'h01FF_8000, mono: 0, rng: 0};
    vecs[2] = '{pat: 2, thr: 0, start_at: -1,  use_model: 0, cks: 32'h01FF_7F3F, mono: 1, rng: 0};
    vecs[3] = '{pat: 3, thr: 0, start_at: -1,  use_model: 0, cks: 32'h0200_7880, mono: 1, rng: 1};
    vecs[4] = '{pat: 0, thr: 0, start_at: 300, use_model: 0, cks: 32'h01FF_8000, mono: 0, rng: 0};
    vecs[5] = '{pat: 5, thr: 1, start_at: -1,  use_model: 1, cks: 0, mono: 0, rng: 0};

    ifc.start = 1'b0; ifc.s_valid = 1'b0; ifc.s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", |{ifc.mem_we, ifc.mem_addr, ifc.mem_wdata, ifc.busy, ifc.s_ready,
                             ifc.table_valid, ifc.err_mono, ifc.err_range, ifc.checksum}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    reset_monitor();
    ifc.s_valid = 1'b1; ifc.s_data = 32'h0000_1234;
    repeat (5) @(posedge clk);
    #1 ifc.s_valid = 1'b0;
    check("idle_no_write", wr_idx, 0);
    check("idle_no_busy", {ifc.busy, ifc.s_ready}, 0);

    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].pat);
      if (vecs[v].use_model) model(cks, mono, rng);
      else begin cks = vecs[v].cks; mono = vecs[v].mono; rng = vecs[v].rng; end
      reset_monitor();
      pulse_start();
      stream(vecs[v].thr, vecs[v].start_at, -1, ab);
      repeat (3) @(posedge clk);
      #1;
      finish_checks($sformatf("vec%0d", v), cks, mono, rng);
      if (vecs[v].pat == 2)
        check("mono_onset", {mono_at[5], mono_at[6], mono_at[1023]}, 3'b011);
      if (vecs[v].pat == 3)
        check("range_onset", {range_at[9], range_at[10], range_at[21], range_at[1023]}, 4'b0111);
    end

    fill(4);
    model(cks, mono, rng);
    reset_monitor();
    pulse_start();
    stream(0, -1, 500, ab);
    check("reset_aborted", ab, 1);
    check("reset_idle_state", {ifc.busy, ifc.s_ready, ifc.table_valid}, 0);
    reset_monitor();
    ifc.s_valid = 1'b1; ifc.s_data = samp[0];
    repeat (4) @(posedge clk);
    #1 ifc.s_valid = 1'b0;
    check("reset_needs_start", wr_idx, 0);
    reset_monitor();
    pulse_start();
    stream(0, -1, -1, ab);
    repeat (3) @(posedge clk);
    #1;
    finish_checks("after_reset", cks, mono, rng);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
